// File: rtl/button_event_arbiter_pkg.sv
// Package button_evt_pkg: shared event/state encodings and sizing helpers
// for button_event_arbiter and its per-button press tracker.
package button_evt_pkg;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'b00,
        EVT_LONG   = 2'b01,
        EVT_REPEAT = 2'b10
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_HELD  = 2'b10
    } btn_state_t;

    // Width of a hold counter that must reach the larger of the two tick limits.
    function automatic int holdCntWidth(input int longTicks, input int repeatTicks);
        int top;
        top = (longTicks > repeatTicks) ? longTicks : repeatTicks;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event port of button_event_arbiter: valid/ready event stream plus the
// overwrite (lost) pulse. master = arbiter side, slave = consumer side.
interface button_event_arbiter_if #(
    parameter int N_BTN = 5
) ();
    import button_evt_pkg::*;

    localparam int ID_W = $clog2(N_BTN);

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    evt_type_t       evt_type;
    logic            evt_lost;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_type,
        output evt_lost,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_type,
        input  evt_lost,
        output evt_ready
    );

endinterface

// File: rtl/button_event_arbiter_btn_press_tracker.sv
// btn_press_tracker: edge detect, press FSM and hold counter for one button.
// Emits a one-cycle post strobe with the event type in the cycle the
// triggering edge or tick is seen.
// Build option: AUTO_REPEAT_EN enables REPEAT events while the button is HELD.
module btn_press_tracker
    import button_evt_pkg::*;
#(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_en,
    input  logic      pb_i,
    output logic      post_o,
    output evt_type_t postType_o
);

`ifdef AUTO_REPEAT_EN
    localparam int CNT_W = holdCntWidth(LONG_TICKS, REPEAT_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`else
    localparam int CNT_W = holdCntWidth(LONG_TICKS, 1);
`endif
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             pbPrev_q;
    btn_state_t       state_q;
    logic [CNT_W-1:0] holdCnt_q;
    logic             rise;
    logic             fall;

    assign rise = pb_i & ~pbPrev_q;
    assign fall = ~pb_i & pbPrev_q;

    // Decode the event to post this cycle from the current state, edge and tick.
    always_comb begin
        post_o     = 1'b0;
        postType_o = EVT_SHORT;
        case (state_q)
            ST_PRESS: begin
                if (fall) begin
                    post_o     = 1'b1;
                    postType_o = EVT_SHORT;
                end else if (tick_en && (holdCnt_q == LONG_LAST)) begin
                    post_o     = 1'b1;
                    postType_o = EVT_LONG;
                end
            end
`ifdef AUTO_REPEAT_EN
            ST_HELD: begin
                if (!fall && tick_en && (holdCnt_q == REPEAT_LAST)) begin
                    post_o     = 1'b1;
                    postType_o = EVT_REPEAT;
                end
            end
`endif
            default: begin
                post_o     = 1'b0;
                postType_o = EVT_SHORT;
            end
        endcase
    end

    // Edge register, press FSM and tick-driven hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbPrev_q  <= 1'b1;
            state_q   <= ST_IDLE;
            holdCnt_q <= '0;
        end else begin
            pbPrev_q <= pb_i;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q   <= ST_PRESS;
                        holdCnt_q <= '0;
                    end
                end
                ST_PRESS: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                    end else if (tick_en) begin
                        if (holdCnt_q == LONG_LAST) begin
                            state_q   <= ST_HELD;
                            holdCnt_q <= '0;
                        end else begin
                            holdCnt_q <= holdCnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                    end else if (tick_en) begin
`ifdef AUTO_REPEAT_EN
                        if (holdCnt_q == REPEAT_LAST) begin
                            holdCnt_q <= '0;
                        end else if (holdCnt_q != CNT_MAX) begin
                            holdCnt_q <= holdCnt_q + CNT_W'(1);
                        end
`else
                        if (holdCnt_q != CNT_MAX) begin
                            holdCnt_q <= holdCnt_q + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns N debounced button levels into SHORT/LONG
// (and optionally REPEAT) events and serialises them round-robin onto one
// valid/ready event port.
// Build option: AUTO_REPEAT_EN (passed down to btn_press_tracker).
module button_event_arbiter
    import button_evt_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_en,
    input  logic [N_BTN-1:0]       pb_deb,
    button_event_arbiter_if.master evt
);

    localparam int ID_W = $clog2(N_BTN);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_BTN - 1);

    logic [N_BTN-1:0] post;
    evt_type_t        postType [N_BTN];

    logic [N_BTN-1:0] pendValid_q;
    evt_type_t        pendType_q [N_BTN];

    logic [N_BTN-1:0] req;
    evt_type_t        reqType [N_BTN];

    logic             evtValid_q;
    logic [ID_W-1:0]  evtId_q;
    evt_type_t        evtType_q;
    logic [ID_W-1:0]  rrPtr_q;

    logic             outFree;
    logic             grantFound;
    logic [ID_W-1:0]  grantId;
    evt_type_t        grantType;
    logic [N_BTN-1:0] grantVec;
    logic             lostAny;

    for (genvar g = 0; g < N_BTN; g++) begin : g_trk
        btn_press_tracker #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_trk (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_en   (tick_en),
            .pb_i      (pb_deb[g]),
            .post_o    (post[g]),
            .postType_o(postType[g])
        );
    end

    assign outFree = ~evtValid_q | evt.evt_ready;

    // A slot requests if it is pending or posting now; an older pending event is served first.
    always_comb begin
        req = pendValid_q | post;
        for (int i = 0; i < N_BTN; i++) begin
            reqType[i] = pendValid_q[i] ? pendType_q[i] : postType[i];
        end
    end

    // Round-robin pick: lowest requester at or above rrPtr_q, else lowest overall.
    always_comb begin
        logic            hiFound;
        logic [ID_W-1:0] hiId;
        evt_type_t       hiType;
        logic            loFound;
        logic [ID_W-1:0] loId;
        evt_type_t       loType;
        hiFound = 1'b0;
        hiId    = '0;
        hiType  = EVT_SHORT;
        loFound = 1'b0;
        loId    = '0;
        loType  = EVT_SHORT;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (req[i]) begin
                loFound = 1'b1;
                loId    = ID_W'(i);
                loType  = reqType[i];
                if (ID_W'(i) >= rrPtr_q) begin
                    hiFound = 1'b1;
                    hiId    = ID_W'(i);
                    hiType  = reqType[i];
                end
            end
        end
        grantFound = loFound;
        grantId    = hiFound ? hiId : loId;
        grantType  = hiFound ? hiType : loType;
    end

    // One-hot view of the grant actually taken this cycle.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            grantVec[i] = outFree & grantFound & (grantId == ID_W'(i));
        end
    end

    assign lostAny = |(post & pendValid_q & ~grantVec);

    // Pending slots: capture posts not taken directly, clear on grant, overwrite on repost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendValid_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                pendType_q[i] <= EVT_SHORT;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (pendValid_q[i]) begin
                    if (post[i]) begin
                        pendType_q[i] <= postType[i];
                    end else if (grantVec[i]) begin
                        pendValid_q[i] <= 1'b0;
                    end
                end else if (post[i] && !grantVec[i]) begin
                    pendValid_q[i] <= 1'b1;
                    pendType_q[i]  <= postType[i];
                end
            end
        end
    end

    // Output register and round-robin pointer; reloads in the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evtValid_q <= 1'b0;
            evtId_q    <= '0;
            evtType_q  <= EVT_SHORT;
            rrPtr_q    <= '0;
        end else if (outFree) begin
            evtValid_q <= grantFound;
            if (grantFound) begin
                evtId_q   <= grantId;
                evtType_q <= grantType;
                rrPtr_q   <= (grantId == LAST_ID) ? '0 : grantId + ID_W'(1);
            end
        end
    end

    assign evt.evt_valid = evtValid_q;
    assign evt.evt_id    = evtId_q;
    assign evt.evt_type  = evtType_q;
    assign evt.evt_lost  = lostAny;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter (N_BTN=5, LONG=20,
// REPEAT=5). Expected ids/types/timing are hand-derived constants.
// Honours AUTO_REPEAT_EN when the build defines it.
module tb_button_event_arbiter;
    import button_evt_pkg::*;

    localparam int N_BTN  = 5;
    localparam int LONG_T = 20;
    localparam int REP_T  = 5;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD_TICKS = 32;
    localparam int HOLD_EVTS  = 3;
`else
    localparam int HOLD_TICKS = LONG_T + 50;
    localparam int HOLD_EVTS  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick_en;
    logic [N_BTN-1:0] pb_deb;
    int               cycleNo = 0;
    int               totalChecks = 0;
    int               badChecks = 0;
    int               lostCount = 0;
    int               lostBase;
    int               stableBad;

    logic [2:0] hsId [$];
    logic [1:0] hsType [$];
    int         hsCyc [$];

    button_event_arbiter_if #(.N_BTN(N_BTN)) evtIf ();

    button_event_arbiter #(
        .N_BTN       (N_BTN),
        .LONG_TICKS  (LONG_T),
        .REPEAT_TICKS(REP_T)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_en(tick_en),
        .pb_deb (pb_deb),
        .evt    (evtIf.master)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp handshakes.
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Record every handshake and lost pulse half a cycle before the edge that commits it.
    always @(negedge clk) begin
        if (rst_n && evtIf.evt_valid && evtIf.evt_ready) begin
            hsId.push_back(evtIf.evt_id);
            hsType.push_back(evtIf.evt_type);
            hsCyc.push_back(cycleNo);
        end
        if (rst_n && evtIf.evt_lost) lostCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tickPulse();
        tick_en = 1'b1;
        stepCycle();
        tick_en = 1'b0;
        stepCycle();
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] pb, input int ticks);
        pb_deb = pb;
        stepCycle();
        for (int i = 0; i < ticks; i++) tickPulse();
    endtask

    task automatic clearLog();
        hsId.delete();
        hsType.delete();
        hsCyc.delete();
    endtask

    function automatic logic [2:0] idAt(input int k);
        return (hsId.size() > k) ? hsId[k] : 3'b111;
    endfunction

    function automatic logic [1:0] typeAt(input int k);
        return (hsType.size() > k) ? hsType[k] : 2'b11;
    endfunction

    initial begin
        rst_n = 1'b0;
        tick_en = 1'b0;
        pb_deb = '0;
        evtIf.evt_ready = 1'b1;
        repeat (3) stepCycle();
        checkOutput("rst_valid", evtIf.evt_valid, 0);
        checkOutput("rst_id", evtIf.evt_id, 0);
        checkOutput("rst_type", evtIf.evt_type, 0);
        checkOutput("rst_lost", evtIf.evt_lost, 0);
        rst_n = 1'b1;
        repeat (2) stepCycle();

        $display("[TB] test 1: short press on btn2");
        clearLog();
        applyStimulus(5'b00100, 10);
        checkOutput("t1_held_valid", evtIf.evt_valid, 0);
        pb_deb = '0;
        checkOutput("t1_release_cycle_valid", evtIf.evt_valid, 0);
        stepCycle();
        checkOutput("t1_valid", evtIf.evt_valid, 1);
        checkOutput("t1_id", evtIf.evt_id, 2);
        checkOutput("t1_type", evtIf.evt_type, EVT_SHORT);
        repeat (4) stepCycle();
        checkOutput("t1_count", hsId.size(), 1);
        checkOutput("t1_after_valid", evtIf.evt_valid, 0);

        $display("[TB] test 2: long hold on btn0");
        clearLog();
        applyStimulus(5'b00001, 0);
        for (int i = 1; i <= HOLD_TICKS; i++) begin
            tickPulse();
            if (i == LONG_T - 1) checkOutput("t2_before_long", hsId.size(), 0);
            if (i == LONG_T) begin
                checkOutput("t2_long_count", hsId.size(), 1);
                checkOutput("t2_long_id", idAt(0), 0);
                checkOutput("t2_long_type", typeAt(0), EVT_LONG);
            end
`ifdef AUTO_REPEAT_EN
            if (i == LONG_T + REP_T - 1) checkOutput("t2_before_rep1", hsId.size(), 1);
            if (i == LONG_T + REP_T) begin
                checkOutput("t2_rep1_count", hsId.size(), 2);
                checkOutput("t2_rep1_type", typeAt(1), EVT_REPEAT);
            end
            if (i == LONG_T + 2 * REP_T) begin
                checkOutput("t2_rep2_count", hsId.size(), 3);
                checkOutput("t2_rep2_type", typeAt(2), EVT_REPEAT);
            end
`endif
        end
        checkOutput("t2_hold_total", hsId.size(), HOLD_EVTS);
        applyStimulus(5'b00000, 0);
        repeat (4) stepCycle();
        checkOutput("t2_release_total", hsId.size(), HOLD_EVTS);

        $display("[TB] test 3: simultaneous shorts on btn1/3/4");
        clearLog();
        lostBase = lostCount;
        applyStimulus(5'b11010, 2);
        applyStimulus(5'b00000, 0);
        repeat (5) stepCycle();
        checkOutput("t3_count", hsId.size(), 3);
        checkOutput("t3_id0", idAt(0), 1);
        checkOutput("t3_id1", idAt(1), 3);
        checkOutput("t3_id2", idAt(2), 4);
        checkOutput("t3_type2", typeAt(2), EVT_SHORT);
        if (hsCyc.size() == 3) begin
            checkOutput("t3_b2b_01", hsCyc[1] - hsCyc[0], 1);
            checkOutput("t3_b2b_12", hsCyc[2] - hsCyc[1], 1);
        end
        checkOutput("t3_lost", lostCount - lostBase, 0);

        $display("[TB] test 4: stalled consumer");
        clearLog();
        evtIf.evt_ready = 1'b0;
        applyStimulus(5'b10100, 1);
        applyStimulus(5'b00000, 0);
        stableBad = 0;
        for (int i = 0; i < 50; i++) begin
            if (evtIf.evt_valid !== 1'b1 || evtIf.evt_id !== 3'd2 || evtIf.evt_type !== EVT_SHORT)
                stableBad++;
            stepCycle();
        end
        checkOutput("t4_stable", stableBad, 0);
        checkOutput("t4_stall_id", evtIf.evt_id, 2);
        checkOutput("t4_stall_count", hsId.size(), 0);
        evtIf.evt_ready = 1'b1;
        repeat (4) stepCycle();
        checkOutput("t4_count", hsId.size(), 2);
        checkOutput("t4_id0", idAt(0), 2);
        checkOutput("t4_id1", idAt(1), 4);

        $display("[TB] test 5: overwrite while stalled");
        clearLog();
        evtIf.evt_ready = 1'b0;
        lostBase = lostCount;
        applyStimulus(5'b00010, 1);
        applyStimulus(5'b00000, 0);
        applyStimulus(5'b00001, 1);
        applyStimulus(5'b00000, 0);
        checkOutput("t5_lost_first", lostCount - lostBase, 0);
        applyStimulus(5'b00001, 1);
        applyStimulus(5'b00000, 0);
        checkOutput("t5_lost", lostCount - lostBase, 1);
        checkOutput("t5_stall_id", evtIf.evt_id, 1);
        evtIf.evt_ready = 1'b1;
        repeat (4) stepCycle();
        checkOutput("t5_count", hsId.size(), 2);
        checkOutput("t5_id0", idAt(0), 1);
        checkOutput("t5_id1", idAt(1), 0);
        checkOutput("t5_lost_final", lostCount - lostBase, 1);

        $display("[TB] test 6: reset mid-press on btn3");
        evtIf.evt_ready = 1'b0;
        applyStimulus(5'b00100, 1);
        applyStimulus(5'b00000, 0);
        checkOutput("t6_pre_valid", evtIf.evt_valid, 1);
        applyStimulus(5'b01000, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", evtIf.evt_valid, 0);
        checkOutput("t6_rst_id", evtIf.evt_id, 0);
        checkOutput("t6_rst_lost", evtIf.evt_lost, 0);
        repeat (2) stepCycle();
        rst_n = 1'b1;
        evtIf.evt_ready = 1'b1;
        clearLog();
        for (int i = 0; i < LONG_T + 5; i++) tickPulse();
        checkOutput("t6_held_count", hsId.size(), 0);
        applyStimulus(5'b00000, 0);
        repeat (3) stepCycle();
        checkOutput("t6_release_count", hsId.size(), 0);
        applyStimulus(5'b01000, 2);
        applyStimulus(5'b00000, 0);
        repeat (3) stepCycle();
        checkOutput("t6_repress_count", hsId.size(), 1);
        checkOutput("t6_repress_id", idAt(0), 3);
        checkOutput("t6_repress_type", typeAt(0), EVT_SHORT);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
